apb_ucpd_tx_ctrl: RTL and testbench

- Sequencing FSM for the UCPD transmit datapath.
- Walks each frame through preamble, SOP, payload, CRC, EOP and inter-frame wait, counting bits on the bit-clock strobe.
- Drives the phase enables, the completion pulses, the TXFIFO load and request strobes, and the discard events.
- Sits between the register block (transmit/hard-reset commands, payload size) and the tx encode/shift datapath.

---
 rtl/apb_ucpd_tx_ctrl_pkg.sv | 34 +++
 rtl/apb_ucpd_edge_det.sv | 19 +
 rtl/apb_ucpd_tx_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_apb_ucpd_tx_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_ucpd_tx_ctrl_pkg.sv
// UCPD transmit sequencer shared definitions.
// State, frame-kind and phase-length constants used by the tx datapath.
package apb_ucpd_tx_ctrl_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_SOP  = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_CRC  = 3'd4;
  localparam logic [2:0] ST_EOP  = 3'd5;
  localparam logic [2:0] ST_WAIT = 3'd6;

  localparam logic [1:0] KIND_MSG  = 2'd0;
  localparam logic [1:0] KIND_HRST = 2'd1;
  localparam logic [1:0] KIND_CRST = 2'd2;

  localparam logic [1:0] MODE_CRST = 2'b01;

  localparam int UCPD_PRE_BITS  = 128;
  localparam int UCPD_SOP_BITS  = 20;
  localparam int UCPD_CRC_BITS  = 40;
  localparam int UCPD_EOP_BITS  = 5;
  localparam int UCPD_WAIT_BITS = 16;
  localparam int UCPD_BYTE_BITS = 10;

  // phases a hard reset may cut short
  function automatic logic abortable(
    input logic [2:0] st
  );
    return (st == ST_PRE) || (st == ST_SOP) ||
           (st == ST_DATA) || (st == ST_CRC);
  endfunction

endpackage

// File: rtl/apb_ucpd_edge_det.sv
// Registered rising-edge detector.
// The history register clears on reset, so a high level counts as an edge.
module apb_ucpd_edge_det (
  input  logic ic_clk,
  input  logic ic_rst,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge ic_clk) begin
    if (ic_rst) sig_q <= 1'b0;
    else        sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/apb_ucpd_tx_ctrl.sv
// UCPD transmit sequencer: preamble, SOP, payload, CRC, EOP, gap.
// Counts bit strobes per phase and drives enables, pulses and requests.
module apb_ucpd_tx_ctrl
  import apb_ucpd_tx_ctrl_pkg::*;
#(
  parameter int PRE_BITS  = UCPD_PRE_BITS,
  parameter int SOP_BITS  = UCPD_SOP_BITS,
  parameter int CRC_BITS  = UCPD_CRC_BITS,
  parameter int EOP_BITS  = UCPD_EOP_BITS,
  parameter int WAIT_BITS = UCPD_WAIT_BITS,
  parameter int PAYSZ_W   = 10
) (
  input  logic               ic_clk,
  input  logic               ic_rst,
  input  logic               bit_clk_red,
  input  logic               transmit_en,
  input  logic               tx_hrst,
  input  logic [1:0]         tx_mode,
  input  logic [PAYSZ_W-1:0] tx_paysz,
  output logic               pre_en,
  output logic               sop_en,
  output logic               data_en,
  output logic               crc_en,
  output logic               eop_en,
  output logic               tx_sop_cmplt,
  output logic               tx_data_cmplt,
  output logic               tx_crc_cmplt,
  output logic               tx_eop_cmplt,
  output logic               tx_wait_cmplt,
  output logic               txfifo_ld_en,
  output logic               txdr_req,
  output logic               tx_msg_disc,
  output logic               tx_hrst_disc,
  output logic               tx_busy
);

  logic [2:0]         state;
  logic [2:0]         nxt;
  logic [1:0]         kind;
  logic [7:0]         bit_cnt;
  logic [7:0]         last_cnt;
  logic [PAYSZ_W-1:0] byte_left;
  logic               hrst_pend;
  logic               req_q;
  logic               msg_rise;
  logic               hrst_rise;
  logic               busy;
  logic               abort;
  logic               phase_end;
  logic               sop_end;
  logic               data_end;
  logic               byte_last;
  logic               is_msg;

  apb_ucpd_edge_det u_msg_edge (
    .ic_clk (ic_clk),
    .ic_rst (ic_rst),
    .sig    (transmit_en),
    .rise   (msg_rise)
  );

  apb_ucpd_edge_det u_hrst_edge (
    .ic_clk (ic_clk),
    .ic_rst (ic_rst),
    .sig    (tx_hrst),
    .rise   (hrst_rise)
  );

  always_comb begin
    last_cnt = 8'd0;
    unique case (state)
      ST_PRE:  last_cnt = 8'(PRE_BITS - 1);
      ST_SOP:  last_cnt = 8'(SOP_BITS - 1);
      ST_DATA: last_cnt = 8'(UCPD_BYTE_BITS - 1);
      ST_CRC:  last_cnt = 8'(CRC_BITS - 1);
      ST_EOP:  last_cnt = 8'(EOP_BITS - 1);
      ST_WAIT: last_cnt = 8'(WAIT_BITS - 1);
      default: last_cnt = 8'd0;
    endcase
  end

  assign busy      = state != ST_IDLE;
  assign is_msg    = kind == KIND_MSG;
  assign byte_last = byte_left == PAYSZ_W'(1);
  assign abort     = hrst_rise && abortable(state)
                  && kind != KIND_HRST;
  assign phase_end = busy && bit_clk_red
                  && bit_cnt == last_cnt;
  assign sop_end   = phase_end && !abort
                  && state == ST_SOP;
  assign data_end  = phase_end && !abort
                  && state == ST_DATA;

  always_comb begin
    nxt = ST_IDLE;
    unique case (state)
      ST_PRE:  nxt = ST_SOP;
      ST_SOP: begin
        if (!is_msg)              nxt = ST_WAIT;
        else if (byte_left == '0) nxt = ST_CRC;
        else                      nxt = ST_DATA;
      end
      ST_DATA: nxt = byte_last ? ST_CRC : ST_DATA;
      ST_CRC:  nxt = ST_EOP;
      ST_EOP:  nxt = ST_WAIT;
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ic_clk) begin
    if (ic_rst) begin
      state     <= ST_IDLE;
      kind      <= KIND_MSG;
      bit_cnt   <= 8'd0;
      byte_left <= '0;
      hrst_pend <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      req_q <= 1'b0;
      if (!busy) begin
        bit_cnt <= 8'd0;
        if (hrst_rise || hrst_pend) begin
          state     <= ST_PRE;
          kind      <= KIND_HRST;
          hrst_pend <= 1'b0;
        end else if (msg_rise) begin
          state     <= ST_PRE;
          kind      <= (tx_mode == MODE_CRST)
                     ? KIND_CRST : KIND_MSG;
          byte_left <= tx_paysz;
          req_q     <= tx_mode != MODE_CRST;
        end
      end else if (abort) begin
        state   <= ST_PRE;
        kind    <= KIND_HRST;
        bit_cnt <= 8'd0;
      end else begin
        // late hard reset waits for the frame to drain
        if (hrst_rise && kind != KIND_HRST &&
            (state == ST_EOP || state == ST_WAIT))
          hrst_pend <= 1'b1;
        if (phase_end) begin
          state   <= nxt;
          bit_cnt <= 8'd0;
          if (state == ST_DATA)
            byte_left <= byte_left - PAYSZ_W'(1);
        end else if (bit_clk_red) begin
          bit_cnt <= bit_cnt + 8'd1;
        end
      end
    end
  end

  assign pre_en  = state == ST_PRE;
  assign sop_en  = state == ST_SOP;
  assign data_en = state == ST_DATA;
  assign crc_en  = state == ST_CRC;
  assign eop_en  = state == ST_EOP;
  assign tx_busy = busy;

  assign tx_sop_cmplt  = sop_end;
  assign tx_data_cmplt = data_end && byte_last;
  assign tx_crc_cmplt  = phase_end && !abort
                      && state == ST_CRC;
  assign tx_eop_cmplt  = phase_end && state == ST_EOP;
  assign tx_wait_cmplt = phase_end && state == ST_WAIT;

  assign txfifo_ld_en = (sop_end && is_msg
                      && byte_left != '0)
                     || (data_end
                      && byte_left > PAYSZ_W'(1));
  assign txdr_req     = req_q || (data_end
                      && byte_left > PAYSZ_W'(2));

  assign tx_msg_disc  = msg_rise
                     && (busy || hrst_pend || hrst_rise);
  assign tx_hrst_disc = hrst_rise
                     && (hrst_pend
                      || (busy && kind == KIND_HRST));

endmodule

// File: tb/tb_apb_ucpd_tx_ctrl.sv
// Randomised bench for apb_ucpd_tx_ctrl.
// Per-frame event counts are compared with a frame-level rule model.
module tb_apb_ucpd_tx_ctrl;

  localparam int PAYSZ_W = 10;
  localparam int KM = 0;
  localparam int KH = 1;
  localparam int KC = 2;
  localparam int NCHK = 15;
  localparam int C_CRCEN = 15;
  localparam int C_OHERR = 16;
  localparam int EV_DONE = 0;
  localparam int EV_D7   = 1;
  localparam int EV_EOP  = 2;
  localparam int EV_WAIT = 3;
  localparam int EV_DATA = 4;
  localparam int EV_SOP  = 5;

  logic ic_clk = 1'b0;
  logic ic_rst;
  logic bit_clk_red;
  logic transmit_en;
  logic tx_hrst;
  logic [1:0] tx_mode;
  logic [PAYSZ_W-1:0] tx_paysz;
  logic pre_en, sop_en, data_en, crc_en, eop_en;
  logic tx_sop_cmplt, tx_data_cmplt, tx_crc_cmplt;
  logic tx_eop_cmplt, tx_wait_cmplt;
  logic txfifo_ld_en, txdr_req;
  logic tx_msg_disc, tx_hrst_disc, tx_busy;
  logic wait_ph;
  logic [14:0] outs;

  int checks = 0;
  int fails = 0;
  int cnt[17];
  int snap[17];

  apb_ucpd_tx_ctrl dut (
    .ic_clk        (ic_clk),
    .ic_rst        (ic_rst),
    .bit_clk_red   (bit_clk_red),
    .transmit_en   (transmit_en),
    .tx_hrst       (tx_hrst),
    .tx_mode       (tx_mode),
    .tx_paysz      (tx_paysz),
    .pre_en        (pre_en),
    .sop_en        (sop_en),
    .data_en       (data_en),
    .crc_en        (crc_en),
    .eop_en        (eop_en),
    .tx_sop_cmplt  (tx_sop_cmplt),
    .tx_data_cmplt (tx_data_cmplt),
    .tx_crc_cmplt  (tx_crc_cmplt),
    .tx_eop_cmplt  (tx_eop_cmplt),
    .tx_wait_cmplt (tx_wait_cmplt),
    .txfifo_ld_en  (txfifo_ld_en),
    .txdr_req      (txdr_req),
    .tx_msg_disc   (tx_msg_disc),
    .tx_hrst_disc  (tx_hrst_disc),
    .tx_busy       (tx_busy)
  );

  always #5 ic_clk = ~ic_clk;

  assign wait_ph = tx_busy
    && !(pre_en | sop_en | data_en | crc_en | eop_en);
  assign outs = {pre_en, sop_en, data_en, crc_en, eop_en,
                 tx_sop_cmplt, tx_data_cmplt, tx_crc_cmplt,
                 tx_eop_cmplt, tx_wait_cmplt, txfifo_ld_en,
                 txdr_req, tx_msg_disc, tx_hrst_disc, tx_busy};

  always @(negedge ic_clk) begin
    cnt[0]  += int'(bit_clk_red & pre_en);
    cnt[1]  += int'(bit_clk_red & sop_en);
    cnt[2]  += int'(bit_clk_red & data_en);
    cnt[3]  += int'(bit_clk_red & crc_en);
    cnt[4]  += int'(bit_clk_red & eop_en);
    cnt[5]  += int'(bit_clk_red & wait_ph);
    cnt[6]  += int'(txdr_req);
    cnt[7]  += int'(txfifo_ld_en);
    cnt[8]  += int'(tx_data_cmplt);
    cnt[9]  += int'(tx_sop_cmplt);
    cnt[10] += int'(tx_crc_cmplt);
    cnt[11] += int'(tx_eop_cmplt);
    cnt[12] += int'(tx_wait_cmplt);
    cnt[13] += int'(tx_msg_disc);
    cnt[14] += int'(tx_hrst_disc);
    cnt[15] += int'(crc_en | eop_en);
    if (!$onehot0({pre_en, sop_en, data_en, crc_en, eop_en}))
      cnt[16] += 1;
  end

  function automatic string cname(input int i);
    case (i)
      0: return "pre_strobes";   1: return "sop_strobes";
      2: return "data_strobes";  3: return "crc_strobes";
      4: return "eop_strobes";   5: return "wait_strobes";
      6: return "txdr_req";      7: return "txfifo_ld_en";
      8: return "data_cmplt";    9: return "sop_cmplt";
      10: return "crc_cmplt";    11: return "eop_cmplt";
      12: return "wait_cmplt";   13: return "msg_disc";
      default: return "hrst_disc";
    endcase
  endfunction

  // whole-frame event totals for a frame of kind k and n bytes
  function automatic int exp_cnt(input int i, input int k,
                                 input int n, input int md,
                                 input int hd);
    int m;
    m = (k == KM) ? 1 : 0;
    case (i)
      0: return 128;
      1: return 20;
      2: return m * 10 * n;
      3: return m * 40;
      4: return m * 5;
      5: return 16;
      6: return m * (1 + ((n > 2) ? n - 2 : 0));
      7: return m * n;
      8: return (m == 1 && n > 0) ? 1 : 0;
      9: return 1;
      10: return m;
      11: return m;
      12: return 1;
      13: return md;
      default: return hd;
    endcase
  endfunction

  task automatic drive_cycle(input logic s, input logic te,
                             input logic hr);
    @(posedge ic_clk);
    #1;
    bit_clk_red = s;
    transmit_en = te;
    tx_hrst = hr;
  endtask

  task automatic take_snap();
    for (int i = 0; i < 17; i++) snap[i] = cnt[i];
  endtask

  task automatic run_to(input int ev, input string nm);
    bit hit;
    hit = 1'b0;
    for (int c = 0; c < 20000 && !hit; c++) begin
      drive_cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      tx_paysz = PAYSZ_W'($urandom);
      @(negedge ic_clk);
      #1;
      case (ev)
        EV_DONE: hit = cnt[12] > snap[12];
        EV_D7:   hit = data_en && (cnt[2] - snap[2]) == 7;
        EV_EOP:  hit = eop_en;
        EV_WAIT: hit = wait_ph;
        EV_DATA: hit = data_en;
        default: hit = sop_en;
      endcase
    end
    checks++;
    if (!hit) begin
      fails++;
      $display("FAIL %s timeout: reached=0 required=1", nm);
    end
  endtask

  task automatic start(input logic [1:0] m, input int n);
    tx_mode = m;
    tx_paysz = PAYSZ_W'(n);
    drive_cycle(1'b0, 1'b1, 1'b0);
  endtask

  task automatic check_idle(input string nm);
    drive_cycle(1'b0, 1'b0, 1'b0);
    @(negedge ic_clk);
    checks++;
    if (tx_busy !== 1'b0) begin
      fails++;
      $display("FAIL %s busy_drop: got %b want 0", nm, tx_busy);
    end
  endtask

  task automatic test_reset();
    ic_rst = 1'b1;
    bit_clk_red = 1'b0;
    transmit_en = 1'b0;
    tx_hrst = 1'b0;
    tx_mode = 2'b00;
    tx_paysz = '0;
    repeat (3) @(posedge ic_clk);
    #1 ic_rst = 1'b0;
    @(negedge ic_clk);
    checks++;
    if (outs !== 15'd0) begin
      fails++;
      $display("FAIL reset outs: got %h want 0", outs);
    end
  endtask

  task automatic test_msg_frame(input int n, input logic [1:0] m,
                                input string nm);
    take_snap();
    start(m, n);
    run_to(EV_DONE, nm);
    for (int i = 0; i < NCHK; i++) begin
      checks++;
      if (cnt[i] - snap[i] !== exp_cnt(i, KM, n, 0, 0)) begin
        fails++;
        $display("FAIL %s %s: got %0d want %0d", nm, cname(i),
                 cnt[i] - snap[i], exp_cnt(i, KM, n, 0, 0));
      end
    end
    check_idle(nm);
  endtask

  task automatic test_zero_payload();
    test_msg_frame(0, 2'b00, "zero_pay");
  endtask

  task automatic test_hrst_abort();
    start(2'b00, 3);
    take_snap();
    run_to(EV_D7, "abort_d7");
    take_snap();
    drive_cycle(1'b0, 1'b0, 1'b1);
    drive_cycle(1'b0, 1'b0, 1'b0);
    @(negedge ic_clk);
    checks++;
    if ({pre_en, data_en} !== 2'b10) begin
      fails++;
      $display("FAIL abort pre_en/data_en: got %b want 10",
               {pre_en, data_en});
    end
    run_to(EV_DONE, "abort");
    for (int i = 0; i < NCHK; i++) begin
      checks++;
      if (cnt[i] - snap[i] !== exp_cnt(i, KH, 0, 0, 0)) begin
        fails++;
        $display("FAIL abort %s: got %0d want %0d", cname(i),
                 cnt[i] - snap[i], exp_cnt(i, KH, 0, 0, 0));
      end
    end
    checks++;
    if (cnt[C_CRCEN] - snap[C_CRCEN] !== 0) begin
      fails++;
      $display("FAIL abort crc_eop_en: got %0d want 0",
               cnt[C_CRCEN] - snap[C_CRCEN]);
    end
    check_idle("abort");
  endtask

  task automatic test_hrst_pend();
    take_snap();
    start(2'b00, 1);
    run_to(EV_EOP, "pend_eop");
    drive_cycle(1'b0, 1'b0, 1'b1);
    run_to(EV_WAIT, "pend_wait");
    drive_cycle(1'b0, 1'b0, 1'b1);
    run_to(EV_DONE, "pend_msg");
    for (int i = 0; i < NCHK; i++) begin
      checks++;
      if (cnt[i] - snap[i] !== exp_cnt(i, KM, 1, 0, 1)) begin
        fails++;
        $display("FAIL pend_msg %s: got %0d want %0d", cname(i),
                 cnt[i] - snap[i], exp_cnt(i, KM, 1, 0, 1));
      end
    end
    check_idle("pend");
    drive_cycle(1'b0, 1'b0, 1'b0);
    @(negedge ic_clk);
    checks++;
    if (pre_en !== 1'b1) begin
      fails++;
      $display("FAIL pend launch pre_en: got %b want 1", pre_en);
    end
    take_snap();
    drive_cycle(1'b0, 1'b0, 1'b1);
    run_to(EV_DONE, "pend_hrst");
    for (int i = 0; i < NCHK; i++) begin
      checks++;
      if (cnt[i] - snap[i] !== exp_cnt(i, KH, 0, 0, 1)) begin
        fails++;
        $display("FAIL pend_hrst %s: got %0d want %0d", cname(i),
                 cnt[i] - snap[i], exp_cnt(i, KH, 0, 0, 1));
      end
    end
    check_idle("pend_hrst");
  endtask

  task automatic test_msg_disc();
    int n;
    n = 2 + int'($urandom_range(0, 3));
    take_snap();
    start(2'b10, n);
    run_to(EV_DATA, "disc_data");
    drive_cycle(1'b0, 1'b1, 1'b0);
    run_to(EV_DONE, "disc_msg");
    for (int i = 0; i < NCHK; i++) begin
      checks++;
      if (cnt[i] - snap[i] !== exp_cnt(i, KM, n, 1, 0)) begin
        fails++;
        $display("FAIL disc_msg %s: got %0d want %0d", cname(i),
                 cnt[i] - snap[i], exp_cnt(i, KM, n, 1, 0));
      end
    end
    check_idle("disc_msg");
    take_snap();
    tx_mode = 2'b00;
    drive_cycle(1'b0, 1'b1, 1'b1);
    run_to(EV_DONE, "simul");
    for (int i = 0; i < NCHK; i++) begin
      checks++;
      if (cnt[i] - snap[i] !== exp_cnt(i, KH, 0, 1, 0)) begin
        fails++;
        $display("FAIL simul %s: got %0d want %0d", cname(i),
                 cnt[i] - snap[i], exp_cnt(i, KH, 0, 1, 0));
      end
    end
    check_idle("simul");
  endtask

  task automatic test_cable_reset();
    take_snap();
    start(2'b01, int'($urandom_range(1, 8)));
    run_to(EV_DONE, "crst");
    for (int i = 0; i < NCHK; i++) begin
      checks++;
      if (cnt[i] - snap[i] !== exp_cnt(i, KC, 0, 0, 0)) begin
        fails++;
        $display("FAIL crst %s: got %0d want %0d", cname(i),
                 cnt[i] - snap[i], exp_cnt(i, KC, 0, 0, 0));
      end
    end
    check_idle("crst");
    start(2'b01, 0);
    run_to(EV_SOP, "rst_sop");
    @(posedge ic_clk);
    #1 ic_rst = 1'b1;
    bit_clk_red = 1'b1;
    @(posedge ic_clk);
    @(negedge ic_clk);
    checks++;
    if (outs !== 15'd0) begin
      fails++;
      $display("FAIL midrst outs: got %h want 0", outs);
    end
    #1 ic_rst = 1'b0;
    bit_clk_red = 1'b0;
    check_idle("midrst");
  endtask

  initial begin
    for (int i = 0; i < 17; i++) cnt[i] = 0;
    test_reset();
    test_msg_frame(2, 2'b00, "msg2");
    test_zero_payload();
    repeat (4)
      test_msg_frame(int'($urandom_range(1, 6)),
                     $urandom_range(0, 1) ? 2'b10 : 2'b00,
                     "msg_rand");
    test_hrst_abort();
    test_hrst_pend();
    test_msg_disc();
    test_cable_reset();
    checks++;
    if (cnt[C_OHERR] !== 0) begin
      fails++;
      $display("FAIL onehot_enables: got %0d bad cycles want 0",
               cnt[C_OHERR]);
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
